// File: rtl/sargantana_icache_pkg.sv
// Shared instruction-cache types and constants: tag controller FSM states,
// replacement LFSR seed/taps and a one-hot decode helper.
package sargantana_icache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REFILL_WR = 2'd1,
      FLUSH     = 2'd2
   } tag_ctrl_state_t;

   localparam logic [7:0] TAG_LFSR_SEED = 8'hA5;
   // Right-shift Galois taps for x^8+x^6+x^5+x^4+1
   localparam logic [7:0] TAG_LFSR_TAPS = 8'hB8;

   localparam int unsigned TAG_ONEHOT_MAX = 32;

   function automatic logic [TAG_ONEHOT_MAX-1:0] tag_onehot(input logic [4:0] idx);
      return TAG_ONEHOT_MAX'(1) << idx;
   endfunction

endpackage

// File: rtl/sargantana_tag_victim_sel.sv
// Refill victim selection: lowest invalid way first, otherwise the replacement
// state (round-robin, or LFSR when SARGANTANA_ICACHE_LFSR_REPL_EN is defined).
module sargantana_tag_victim_sel
   import sargantana_icache_pkg::*;
#(
   parameter int unsigned NUM_WAYS = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NUM_WAYS-1:0] vbit_i,
   input  logic                advance_i,
   output logic [NUM_WAYS-1:0] victim_oh_o
);

   localparam int unsigned IDX_W = $clog2(NUM_WAYS);

   logic [NUM_WAYS-1:0] w_free;
   logic [NUM_WAYS-1:0] w_free_oh;
   logic [NUM_WAYS-1:0] w_repl_oh;
   logic [IDX_W-1:0]    w_repl_idx;
   logic                w_all_valid;
   logic                w_step;

   assign w_free      = ~vbit_i;
   assign w_free_oh   = w_free & (~w_free + NUM_WAYS'(1));
   assign w_all_valid = &vbit_i;
   assign w_step      = advance_i & w_all_valid;
   assign w_repl_oh   = NUM_WAYS'(tag_onehot(5'(w_repl_idx)));
   assign victim_oh_o = w_all_valid ? w_repl_oh : w_free_oh;

`ifdef SARGANTANA_ICACHE_LFSR_REPL_EN
   logic [7:0] r_lfsr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lfsr <= TAG_LFSR_SEED;
      end else if (w_step) begin
         r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? TAG_LFSR_TAPS : 8'h00);
      end
   end

   assign w_repl_idx = r_lfsr[IDX_W-1:0];
`else
   logic [IDX_W-1:0] r_rr_ptr;

   // Power-of-two way count makes the natural wrap the modulo
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rr_ptr <= '0;
      end else if (w_step) begin
         r_rr_ptr <= r_rr_ptr + IDX_W'(1);
      end
   end

   assign w_repl_idx = r_rr_ptr;
`endif

endmodule

// File: rtl/sargantana_tag_way_ctrl.sv
// Icache tag-way controller: pipelined lookups, refill victim write and flush
// sequencing. Optional LFSR replacement via SARGANTANA_ICACHE_LFSR_REPL_EN.
module sargantana_tag_way_ctrl
   import sargantana_icache_pkg::*;
#(
   parameter int unsigned NUM_WAYS       = 4,
   parameter int unsigned TAG_DEPTH      = 64,
   parameter int unsigned TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
   parameter int unsigned TAG_WIDHT      = 20
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          lookup_valid_i,
   output logic                          lookup_ready_o,
   input  logic [TAG_ADDR_WIDHT-1:0]     lookup_idx_i,
   input  logic [TAG_WIDHT-1:0]          lookup_tag_i,
   output logic                          resp_valid_o,
   output logic                          resp_hit_o,
   output logic [NUM_WAYS-1:0]           resp_way_o,
   input  logic                          refill_valid_i,
   output logic                          refill_ready_o,
   input  logic [TAG_ADDR_WIDHT-1:0]     refill_idx_i,
   input  logic [TAG_WIDHT-1:0]          refill_tag_i,
   output logic                          refill_done_o,
   output logic [NUM_WAYS-1:0]           refill_way_o,
   input  logic                          flush_i,
   output logic [NUM_WAYS-1:0]           tag_req_o,
   output logic                          tag_we_o,
   output logic                          tag_vbit_o,
   output logic                          tag_flush_o,
   output logic [TAG_ADDR_WIDHT-1:0]     tag_addr_o,
   output logic [TAG_WIDHT-1:0]          tag_data_o,
   input  logic [NUM_WAYS*TAG_WIDHT-1:0] tag_data_i,
   input  logic [NUM_WAYS-1:0]           tag_vbit_i
);

   tag_ctrl_state_t             r_state;
   logic                        r_s1_valid;
   logic [TAG_WIDHT-1:0]        r_s1_tag;
   logic                        r_s2_valid;
   logic                        r_s2_hit;
   logic [NUM_WAYS-1:0]         r_s2_way;
   logic [TAG_ADDR_WIDHT-1:0]   r_ref_idx;
   logic [TAG_WIDHT-1:0]        r_ref_tag;

   logic                        w_refill_ready;
   logic                        w_lookup_ready;
   logic                        w_refill_acc;
   logic                        w_lookup_acc;
   logic                        w_wr_active;
   logic [NUM_WAYS-1:0]         w_hit;
   logic [NUM_WAYS-1:0]         w_hit_oh;
   logic [NUM_WAYS-1:0]         w_victim_oh;

   assign w_refill_ready = (r_state == IDLE) & ~flush_i & ~rst_i;
   assign w_lookup_ready = w_refill_ready & ~refill_valid_i;
   assign w_refill_acc   = refill_valid_i & w_refill_ready;
   assign w_lookup_acc   = lookup_valid_i & w_lookup_ready;
   assign w_wr_active    = (r_state == REFILL_WR) & ~rst_i;

   assign refill_ready_o = w_refill_ready;
   assign lookup_ready_o = w_lookup_ready;

   // Stage-1 tag compare against the per-way read data
   always_comb begin
      w_hit = '0;
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
         w_hit[w] = tag_vbit_i[w] & (tag_data_i[w*TAG_WIDHT +: TAG_WIDHT] == r_s1_tag);
      end
   end

   assign w_hit_oh = w_hit & (~w_hit + NUM_WAYS'(1));

   sargantana_tag_victim_sel #(
      .NUM_WAYS (NUM_WAYS)
   ) u_victim_sel (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .vbit_i      (tag_vbit_i),
      .advance_i   (w_wr_active),
      .victim_oh_o (w_victim_oh)
   );

   // Memory port is driven in the accept/write cycle itself
   always_comb begin
      tag_req_o     = '0;
      tag_we_o      = 1'b0;
      tag_vbit_o    = 1'b0;
      tag_flush_o   = 1'b0;
      tag_addr_o    = '0;
      tag_data_o    = '0;
      refill_done_o = 1'b0;
      refill_way_o  = '0;
      if (!rst_i) begin
         case (r_state)
            IDLE: begin
               if (w_refill_acc) begin
                  tag_req_o  = '1;
                  tag_addr_o = refill_idx_i;
               end else if (w_lookup_acc) begin
                  tag_req_o  = '1;
                  tag_addr_o = lookup_idx_i;
               end
            end
            REFILL_WR: begin
               tag_req_o     = w_victim_oh;
               tag_we_o      = 1'b1;
               tag_vbit_o    = 1'b1;
               tag_addr_o    = r_ref_idx;
               tag_data_o    = r_ref_tag;
               refill_done_o = 1'b1;
               refill_way_o  = w_victim_oh;
            end
            FLUSH: begin
               tag_flush_o = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // A flush seen while a result sits in stage 2 also suppresses its hit
   assign resp_valid_o = r_s2_valid;
   assign resp_hit_o   = r_s2_hit & ~flush_i;
   assign resp_way_o   = r_s2_way & {NUM_WAYS{~flush_i}};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_s1_valid <= 1'b0;
         r_s1_tag   <= '0;
         r_s2_valid <= 1'b0;
         r_s2_hit   <= 1'b0;
         r_s2_way   <= '0;
         r_ref_idx  <= '0;
         r_ref_tag  <= '0;
      end else begin
         r_s1_valid <= w_lookup_acc;
         if (w_lookup_acc) begin
            r_s1_tag <= lookup_tag_i;
         end
         r_s2_valid <= r_s1_valid;
         r_s2_hit   <= r_s1_valid & ~flush_i & (|w_hit);
         r_s2_way   <= (r_s1_valid & ~flush_i) ? w_hit_oh : '0;
         if (w_refill_acc) begin
            r_ref_idx <= refill_idx_i;
            r_ref_tag <= refill_tag_i;
         end
         if (flush_i) begin
            r_state <= FLUSH;
         end else begin
            case (r_state)
               IDLE:      r_state <= w_refill_acc ? REFILL_WR : IDLE;
               REFILL_WR: r_state <= IDLE;
               FLUSH:     r_state <= IDLE;
               default:   r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sargantana_tag_way_ctrl.sv
// Directed self-checking bench for sargantana_tag_way_ctrl with a behavioural
// tag-way memory (registered read, write on req&we, flush clears valid bits).
module tb_sargantana_tag_way_ctrl;

   localparam int unsigned NW = 4;
   localparam int unsigned AW = 6;
   localparam int unsigned TW = 20;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          lookup_valid_i;
   logic          lookup_ready_o;
   logic [AW-1:0] lookup_idx_i;
   logic [TW-1:0] lookup_tag_i;
   logic          resp_valid_o;
   logic          resp_hit_o;
   logic [NW-1:0] resp_way_o;
   logic          refill_valid_i;
   logic          refill_ready_o;
   logic [AW-1:0] refill_idx_i;
   logic [TW-1:0] refill_tag_i;
   logic          refill_done_o;
   logic [NW-1:0] refill_way_o;
   logic          flush_i;
   logic [NW-1:0] tag_req_o;
   logic          tag_we_o;
   logic          tag_vbit_o;
   logic          tag_flush_o;
   logic [AW-1:0] tag_addr_o;
   logic [TW-1:0] tag_data_o;
   logic [NW*TW-1:0] tag_data_i;
   logic [NW-1:0] tag_vbit_i;

   logic          mem_clr;
   logic [TW-1:0] mem_tag [NW][64];
   logic          mem_v   [NW][64];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   sargantana_tag_way_ctrl #(
      .NUM_WAYS(NW), .TAG_DEPTH(64), .TAG_ADDR_WIDHT(AW), .TAG_WIDHT(TW)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
      .lookup_idx_i(lookup_idx_i), .lookup_tag_i(lookup_tag_i),
      .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_way_o(resp_way_o),
      .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o),
      .refill_idx_i(refill_idx_i), .refill_tag_i(refill_tag_i),
      .refill_done_o(refill_done_o), .refill_way_o(refill_way_o),
      .flush_i(flush_i),
      .tag_req_o(tag_req_o), .tag_we_o(tag_we_o), .tag_vbit_o(tag_vbit_o),
      .tag_flush_o(tag_flush_o), .tag_addr_o(tag_addr_o), .tag_data_o(tag_data_o),
      .tag_data_i(tag_data_i), .tag_vbit_i(tag_vbit_i)
   );

   // Tag-way memory model
   always @(posedge clk_i) begin
      if (mem_clr) begin
         for (int w = 0; w < NW; w++) begin
            for (int s = 0; s < 64; s++) begin
               mem_v[w][s]   <= 1'b0;
               mem_tag[w][s] <= '0;
            end
         end
         tag_data_i <= '0;
         tag_vbit_i <= '0;
      end else begin
         for (int w = 0; w < NW; w++) begin
            if (tag_req_o[w]) begin
               if (tag_we_o) begin
                  mem_tag[w][tag_addr_o] <= tag_data_o;
                  mem_v[w][tag_addr_o]   <= tag_vbit_o;
               end else begin
                  tag_data_i[w*TW +: TW] <= mem_tag[w][tag_addr_o];
                  tag_vbit_i[w]          <= mem_v[w][tag_addr_o];
               end
            end
         end
         if (tag_flush_o) begin
            for (int w = 0; w < NW; w++) begin
               for (int s = 0; s < 64; s++) mem_v[w][s] <= 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic do_refill(input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                            output logic done, output logic [NW-1:0] way);
      @(negedge clk_i);
      refill_valid_i = 1'b1; refill_idx_i = idx; refill_tag_i = tag;
      @(negedge clk_i);
      refill_valid_i = 1'b0;
      #1;
      done = refill_done_o; way = refill_way_o;
   endtask

   task automatic do_lookup(input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                            output logic v, output logic h, output logic [NW-1:0] way);
      @(negedge clk_i);
      lookup_valid_i = 1'b1; lookup_idx_i = idx; lookup_tag_i = tag;
      @(negedge clk_i);
      lookup_valid_i = 1'b0;
      @(negedge clk_i);
      #1;
      v = resp_valid_o; h = resp_hit_o; way = resp_way_o;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; mem_clr = 1'b1;
      lookup_valid_i = 1'b0; lookup_idx_i = '0; lookup_tag_i = '0;
      refill_valid_i = 1'b0; refill_idx_i = '0; refill_tag_i = '0; flush_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0; mem_clr = 1'b0;
      #1;
      n_tests++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid_o); end
      n_tests++; if (refill_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_refill_done got %b exp 0", refill_done_o); end
      n_tests++; if (tag_req_o !== 4'b0000) begin n_fail++; $display("FAIL reset_tag_req got %b exp 0000", tag_req_o); end
      n_tests++; if (tag_flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_tag_flush got %b exp 0", tag_flush_o); end
      n_tests++; if (refill_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_refill_ready got %b exp 1", refill_ready_o); end
      n_tests++; if (lookup_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_lookup_ready got %b exp 1", lookup_ready_o); end
   endtask

   task automatic test_lookup_after_refill();
      logic d, v, h; logic [NW-1:0] w;
      do_refill(6'd5, 20'hABCDE, d, w);
      n_tests++; if (d !== 1'b1) begin n_fail++; $display("FAIL refill5_done got %b exp 1", d); end
      n_tests++; if (w !== 4'b0001) begin n_fail++; $display("FAIL refill5_way got %b exp 0001", w); end
      do_lookup(6'd5, 20'hABCDE, v, h, w);
      n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL lk5_valid got %b exp 1", v); end
      n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL lk5_hit got %b exp 1", h); end
      n_tests++; if (w !== 4'b0001) begin n_fail++; $display("FAIL lk5_way got %b exp 0001", w); end
      do_lookup(6'd5, 20'hABCDF, v, h, w);
      n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL lk5miss_valid got %b exp 1", v); end
      n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL lk5miss_hit got %b exp 0", h); end
      n_tests++; if (w !== 4'b0000) begin n_fail++; $display("FAIL lk5miss_way got %b exp 0000", w); end
   endtask

   task automatic test_back_to_back();
      logic d; logic [NW-1:0] w;
      logic [TW-1:0] ltag [4];
      logic          exp_h [4];
      logic [NW-1:0] exp_w [4];
      do_refill(6'd0, 20'h00100, d, w);
      do_refill(6'd1, 20'h00101, d, w);
      do_refill(6'd2, 20'h00102, d, w);
      do_refill(6'd3, 20'h00103, d, w);
      do_refill(6'd2, 20'h00222, d, w);
      n_tests++; if (w !== 4'b0010) begin n_fail++; $display("FAIL refill2b_way got %b exp 0010", w); end
      ltag[0] = 20'h00100; exp_h[0] = 1'b1; exp_w[0] = 4'b0001;
      ltag[1] = 20'h00999; exp_h[1] = 1'b0; exp_w[1] = 4'b0000;
      ltag[2] = 20'h00222; exp_h[2] = 1'b1; exp_w[2] = 4'b0010;
      ltag[3] = 20'h00103; exp_h[3] = 1'b1; exp_w[3] = 4'b0001;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_i);
         if (c < 4) begin
            lookup_valid_i = 1'b1; lookup_idx_i = AW'(c); lookup_tag_i = ltag[c];
         end else begin
            lookup_valid_i = 1'b0;
         end
         #1;
         if (c < 4) begin
            n_tests++; if (lookup_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b exp 1", c, lookup_ready_o); end
         end
         if (c >= 2) begin
            n_tests++; if (resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b exp 1", c-2, resp_valid_o); end
            n_tests++; if (resp_hit_o !== exp_h[c-2]) begin n_fail++; $display("FAIL b2b_hit[%0d] got %b exp %b", c-2, resp_hit_o, exp_h[c-2]); end
            n_tests++; if (resp_way_o !== exp_w[c-2]) begin n_fail++; $display("FAIL b2b_way[%0d] got %b exp %b", c-2, resp_way_o, exp_w[c-2]); end
         end
      end
      @(negedge clk_i); #1;
      n_tests++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_end got %b exp 0", resp_valid_o); end
   endtask

   task automatic test_all_valid_replacement();
      logic d; logic [NW-1:0] w;
      logic [NW-1:0] exp_w [6];
      exp_w[0] = 4'b0001; exp_w[1] = 4'b0010; exp_w[2] = 4'b0100; exp_w[3] = 4'b1000;
`ifdef SARGANTANA_ICACHE_LFSR_REPL_EN
      exp_w[4] = 4'b0010;   // LFSR 0xA5 -> low bits 01
      exp_w[5] = 4'b0100;   // LFSR 0xEA -> low bits 10
`else
      exp_w[4] = 4'b0001;
      exp_w[5] = 4'b0010;
`endif
      for (int i = 0; i < 6; i++) begin
         do_refill(6'd9, TW'(32'h90 + i), d, w);
         n_tests++; if (w !== exp_w[i]) begin n_fail++; $display("FAIL repl9_way[%0d] got %b exp %b", i, w, exp_w[i]); end
      end
   endtask

   task automatic test_flush_mid_lookup();
      logic v, h; logic [NW-1:0] w;
      @(negedge clk_i);
      lookup_valid_i = 1'b1; lookup_idx_i = 6'd5; lookup_tag_i = 20'hABCDE;
      @(negedge clk_i);
      lookup_valid_i = 1'b0; flush_i = 1'b1;
      #1;
      n_tests++; if (lookup_ready_o !== 1'b0) begin n_fail++; $display("FAIL flushF_lookup_ready got %b exp 0", lookup_ready_o); end
      n_tests++; if (refill_ready_o !== 1'b0) begin n_fail++; $display("FAIL flushF_refill_ready got %b exp 0", refill_ready_o); end
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      n_tests++; if (resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_resp_valid got %b exp 1", resp_valid_o); end
      n_tests++; if (resp_hit_o !== 1'b0) begin n_fail++; $display("FAIL flush_resp_hit got %b exp 0", resp_hit_o); end
      n_tests++; if (resp_way_o !== 4'b0000) begin n_fail++; $display("FAIL flush_resp_way got %b exp 0000", resp_way_o); end
      n_tests++; if (tag_flush_o !== 1'b1) begin n_fail++; $display("FAIL flush_tag_flush got %b exp 1", tag_flush_o); end
      n_tests++; if (lookup_ready_o !== 1'b0) begin n_fail++; $display("FAIL flushF1_lookup_ready got %b exp 0", lookup_ready_o); end
      @(negedge clk_i); #1;
      n_tests++; if (tag_flush_o !== 1'b0) begin n_fail++; $display("FAIL flush_done_tag_flush got %b exp 0", tag_flush_o); end
      n_tests++; if (lookup_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_done_lookup_ready got %b exp 1", lookup_ready_o); end
      do_lookup(6'd5, 20'hABCDE, v, h, w);
      n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL postflush_valid got %b exp 1", v); end
      n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL postflush_hit got %b exp 0", h); end
   endtask

   task automatic test_simultaneous();
      @(negedge clk_i);
      refill_valid_i = 1'b1; refill_idx_i = 6'd20; refill_tag_i = 20'h00077;
      lookup_valid_i = 1'b1; lookup_idx_i = 6'd20; lookup_tag_i = 20'h00077;
      #1;
      n_tests++; if (lookup_ready_o !== 1'b0) begin n_fail++; $display("FAIL simM_lookup_ready got %b exp 0", lookup_ready_o); end
      n_tests++; if (refill_ready_o !== 1'b1) begin n_fail++; $display("FAIL simM_refill_ready got %b exp 1", refill_ready_o); end
      @(negedge clk_i);
      refill_valid_i = 1'b0;
      #1;
      n_tests++; if (lookup_ready_o !== 1'b0) begin n_fail++; $display("FAIL simM1_lookup_ready got %b exp 0", lookup_ready_o); end
      n_tests++; if (refill_ready_o !== 1'b0) begin n_fail++; $display("FAIL simM1_refill_ready got %b exp 0", refill_ready_o); end
      n_tests++; if (refill_done_o !== 1'b1) begin n_fail++; $display("FAIL simM1_refill_done got %b exp 1", refill_done_o); end
      n_tests++; if (refill_way_o !== 4'b0001) begin n_fail++; $display("FAIL simM1_refill_way got %b exp 0001", refill_way_o); end
      @(negedge clk_i); #1;
      n_tests++; if (lookup_ready_o !== 1'b1) begin n_fail++; $display("FAIL simM2_lookup_ready got %b exp 1", lookup_ready_o); end
      @(negedge clk_i);
      lookup_valid_i = 1'b0;
      @(negedge clk_i); #1;
      n_tests++; if (resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL sim_resp_valid got %b exp 1", resp_valid_o); end
      n_tests++; if (resp_hit_o !== 1'b1) begin n_fail++; $display("FAIL sim_resp_hit got %b exp 1", resp_hit_o); end
      n_tests++; if (resp_way_o !== 4'b0001) begin n_fail++; $display("FAIL sim_resp_way got %b exp 0001", resp_way_o); end
   endtask

   task automatic test_reset_mid_refill();
      logic v, h; logic [NW-1:0] w;
      @(negedge clk_i);
      refill_valid_i = 1'b1; refill_idx_i = 6'd30; refill_tag_i = 20'h00055;
      @(negedge clk_i);
      refill_valid_i = 1'b0; rst_i = 1'b1;
      #1;
      n_tests++; if (refill_done_o !== 1'b0) begin n_fail++; $display("FAIL rstwr_refill_done got %b exp 0", refill_done_o); end
      n_tests++; if (tag_we_o !== 1'b0) begin n_fail++; $display("FAIL rstwr_tag_we got %b exp 0", tag_we_o); end
      n_tests++; if (tag_req_o !== 4'b0000) begin n_fail++; $display("FAIL rstwr_tag_req got %b exp 0000", tag_req_o); end
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      n_tests++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_after_resp_valid got %b exp 0", resp_valid_o); end
      n_tests++; if (refill_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_after_refill_done got %b exp 0", refill_done_o); end
      n_tests++; if (refill_way_o !== 4'b0000) begin n_fail++; $display("FAIL rst_after_refill_way got %b exp 0000", refill_way_o); end
      n_tests++; if (tag_req_o !== 4'b0000) begin n_fail++; $display("FAIL rst_after_tag_req got %b exp 0000", tag_req_o); end
      n_tests++; if (tag_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_after_tag_we got %b exp 0", tag_we_o); end
      n_tests++; if (tag_vbit_o !== 1'b0) begin n_fail++; $display("FAIL rst_after_tag_vbit got %b exp 0", tag_vbit_o); end
      n_tests++; if (tag_flush_o !== 1'b0) begin n_fail++; $display("FAIL rst_after_tag_flush got %b exp 0", tag_flush_o); end
      do_lookup(6'd30, 20'h00055, v, h, w);
      n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL rst_lk30_valid got %b exp 1", v); end
      n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL rst_lk30_hit got %b exp 0", h); end
   endtask

   initial begin
      test_reset();
      test_lookup_after_refill();
      test_back_to_back();
      test_all_valid_replacement();
      test_flush_mid_lookup();
      test_simultaneous();
      test_reset_mid_refill();
      repeat (2) @(negedge clk_i);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
